irs_stats_sequencer: RTL

Measurement-window controller that produces the per-daughter 8-bit deadtime, average occupancy and maximum occupancy values consumed by the IRS statistics register block. It runs a free-running window timer, accumulates per-cycle busy flags and occupancy samples for up to four daughters, and at each window boundary latches scaled results into stable output registers with a one-cycle update strobe. Wishbone readback stays in the statistics block; this block only sequences and computes the values.

---
 rtl/irs_stats_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/irs_stats_sequencer.sv
// Window controller for IRS daughter statistics: accumulates deadtime flags and
// occupancy per lane over 2^WINDOW_BITS enabled cycles and latches scaled results.
module irs_stats_sequencer #(
   parameter int NUM_DAUGHTERS = 4,
   parameter int WINDOW_BITS   = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        restart_i,
   input  logic [3:0]  dead_i,
   input  logic [31:0] occupancy_i,
   output logic [31:0] deadtime_o,
   output logic [31:0] occupancy_o,
   output logic [31:0] max_occupancy_o,
   output logic        update_o
);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam logic [WINDOW_BITS-1:0] WCNT_ONE  = 1;
   localparam logic [WINDOW_BITS-1:0] WCNT_LAST = '1;

   state_t                 state;
   logic [WINDOW_BITS-1:0] wcnt_q, wcnt_d;
   logic                   update_q, update_d;
   logic                   advance;
   logic                   terminal;

   // HOLD follows enable_i with no registered latency, so the state is decoded
   // combinationally each cycle instead of being stored.
   always_comb begin
      state = enable_i ? ST_ACCUM : ST_HOLD;
   end

   always_comb begin
      advance  = (state == ST_ACCUM) && !restart_i;
      terminal = advance && (wcnt_q == WCNT_LAST);
      wcnt_d   = wcnt_q;
      update_d = 1'b0;
      if (restart_i) begin
         wcnt_d = '0;
      end else if (advance) begin
         wcnt_d   = terminal ? '0 : (wcnt_q + WCNT_ONE);
         update_d = terminal;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wcnt_q   <= '0;
         update_q <= 1'b0;
      end else begin
         wcnt_q   <= wcnt_d;
         update_q <= update_d;
      end
   end

   assign update_o = update_q;

   for (genvar d = 0; d < 4; d++) begin : g_lane
      if (d < NUM_DAUGHTERS) begin : g_on
         logic [WINDOW_BITS:0]   dcnt_q, dcnt_d, dcnt_sum;
         logic [WINDOW_BITS+7:0] oacc_q, oacc_d, oacc_sum;
         logic [7:0]             omax_q, omax_d, omax_new;
         logic [7:0]             occ;
         logic [8:0]             dslice;
         logic [7:0]             dead_out_q, dead_out_d;
         logic [7:0]             occ_out_q, occ_out_d;
         logic [7:0]             max_out_q, max_out_d;

         always_comb begin
            occ      = occupancy_i[8*d +: 8];
            dcnt_sum = dcnt_q + {{WINDOW_BITS{1'b0}}, dead_i[d]};
            oacc_sum = oacc_q + {{WINDOW_BITS{1'b0}}, occ};
            omax_new = (occ > omax_q) ? occ : omax_q;
            // A fully dead window counts to exactly 2^WINDOW_BITS, which lands in bit 8.
            dslice   = dcnt_sum[WINDOW_BITS -: 9];

            dcnt_d     = dcnt_q;
            oacc_d     = oacc_q;
            omax_d     = omax_q;
            dead_out_d = dead_out_q;
            occ_out_d  = occ_out_q;
            max_out_d  = max_out_q;
            if (restart_i) begin
               dcnt_d = '0;
               oacc_d = '0;
               omax_d = '0;
            end else if (terminal) begin
               dead_out_d = dslice[8] ? 8'hFF : dslice[7:0];
               occ_out_d  = oacc_sum[WINDOW_BITS +: 8];
               max_out_d  = omax_new;
               dcnt_d     = '0;
               oacc_d     = '0;
               omax_d     = '0;
            end else if (advance) begin
               dcnt_d = dcnt_sum;
               oacc_d = oacc_sum;
               omax_d = omax_new;
            end
         end

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               dcnt_q     <= '0;
               oacc_q     <= '0;
               omax_q     <= '0;
               dead_out_q <= '0;
               occ_out_q  <= '0;
               max_out_q  <= '0;
            end else begin
               dcnt_q     <= dcnt_d;
               oacc_q     <= oacc_d;
               omax_q     <= omax_d;
               dead_out_q <= dead_out_d;
               occ_out_q  <= occ_out_d;
               max_out_q  <= max_out_d;
            end
         end

         assign deadtime_o[8*d +: 8]      = dead_out_q;
         assign occupancy_o[8*d +: 8]     = occ_out_q;
         assign max_occupancy_o[8*d +: 8] = max_out_q;
      end else begin : g_off
         logic lane_unused;
         assign lane_unused = ^{dead_i[d], occupancy_i[8*d +: 8]};

         assign deadtime_o[8*d +: 8]      = 8'h00;
         assign occupancy_o[8*d +: 8]     = 8'h00;
         assign max_occupancy_o[8*d +: 8] = 8'h00;
      end
   end

endmodule
